hermes_ni_tx: RTL and testbench

Network-interface transmit stage sitting directly upstream of a Hermes router's local input port. Accepts a packet request (target address, payload length) and a payload flit stream, and serialises them into a Hermes packet (header flit, size flit, payload flits) on the router's credit-based rx/credit/data link. Shared by every PE that injects traffic into the NoC.

---
 rtl/hermes_ni_tx.sv | 184 ++++++++++++++++++
 tb/tb_hermes_ni_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hermes_ni_tx.sv
// Hermes NI transmit stage: serialises header, size and payload flits onto the router local port.
// Define HERMES_NI_TX_CHECKSUM_EN to append an XOR checksum trailer flit to every packet.
module hermes_ni_tx #(
  parameter int unsigned FLIT_SIZE = 32,
  parameter logic [15:0] MAX_LEN   = 16'hFFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [15:0]          req_target_i,
  input  logic [15:0]          req_len_i,
  input  logic                 pld_valid_i,
  output logic                 pld_ready_o,
  input  logic [FLIT_SIZE-1:0] pld_data_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 busy_o,
  output logic                 pkt_sent_o
);

`ifdef HERMES_NI_TX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HEADER, SIZE, PAYLOAD, TRAILER} state_t;
`else
  typedef enum logic [2:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;
`endif

  state_t         state_reg, state_next;
  logic [15:0]    target_reg, target_next;
  logic [15:0]    len_reg, len_next;
  logic [15:0]    cnt_reg, cnt_next;
  logic           pkt_sent_reg, pkt_sent_next;
  logic [15:0]    len_clamped;
  logic [FLIT_SIZE-1:0] header_flit;
  logic [FLIT_SIZE-1:0] size_flit;

`ifdef HERMES_NI_TX_CHECKSUM_EN
  logic [FLIT_SIZE-1:0] cs_reg, cs_next;
`endif

  // ">=" rather than ">" keeps the compare meaningful when MAX_LEN is all ones
  assign len_clamped = (req_len_i >= MAX_LEN) ? MAX_LEN : req_len_i;
  assign header_flit = {{(FLIT_SIZE-16){1'b0}}, target_reg};

`ifdef HERMES_NI_TX_CHECKSUM_EN
  assign size_flit = {{(FLIT_SIZE-16){1'b0}}, len_reg} + {{(FLIT_SIZE-1){1'b0}}, 1'b1};
`else
  assign size_flit = {{(FLIT_SIZE-16){1'b0}}, len_reg};
`endif

  assign pkt_sent_o = pkt_sent_reg & rst_ni;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      target_reg   <= '0;
      len_reg      <= '0;
      cnt_reg      <= '0;
      pkt_sent_reg <= 1'b0;
`ifdef HERMES_NI_TX_CHECKSUM_EN
      cs_reg       <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      target_reg   <= target_next;
      len_reg      <= len_next;
      cnt_reg      <= cnt_next;
      pkt_sent_reg <= pkt_sent_next;
`ifdef HERMES_NI_TX_CHECKSUM_EN
      cs_reg       <= cs_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    target_next   = target_reg;
    len_next      = len_reg;
    cnt_next      = cnt_reg;
    pkt_sent_next = 1'b0;
    req_ready_o   = 1'b0;
    pld_ready_o   = 1'b0;
    tx_o          = 1'b0;
    data_o        = '0;
    busy_o        = 1'b1;
`ifdef HERMES_NI_TX_CHECKSUM_EN
    cs_next       = cs_reg;
`endif

    case (state_reg)
      IDLE: begin
        busy_o      = 1'b0;
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          target_next = req_target_i;
          len_next    = len_clamped;
          cnt_next    = len_clamped;
          state_next  = HEADER;
`ifdef HERMES_NI_TX_CHECKSUM_EN
          cs_next     = '0;
`endif
        end
      end

      HEADER: begin
        tx_o   = 1'b1;
        data_o = header_flit;
        if (credit_i) begin
          state_next = SIZE;
`ifdef HERMES_NI_TX_CHECKSUM_EN
          cs_next    = cs_reg ^ header_flit;
`endif
        end
      end

      SIZE: begin
        tx_o   = 1'b1;
        data_o = size_flit;
        if (credit_i) begin
`ifdef HERMES_NI_TX_CHECKSUM_EN
          cs_next = cs_reg ^ size_flit;
`endif
          if (len_reg != 16'd0) begin
            state_next = PAYLOAD;
          end else begin
`ifdef HERMES_NI_TX_CHECKSUM_EN
            state_next    = TRAILER;
`else
            state_next    = IDLE;
            pkt_sent_next = 1'b1;
`endif
          end
        end
      end

      PAYLOAD: begin
        // Stalls are driven by the source here; tx_o simply follows pld_valid_i
        tx_o        = pld_valid_i;
        data_o      = pld_valid_i ? pld_data_i : '0;
        pld_ready_o = credit_i;
        if (pld_valid_i && credit_i) begin
          cnt_next = cnt_reg - 16'd1;
`ifdef HERMES_NI_TX_CHECKSUM_EN
          cs_next  = cs_reg ^ pld_data_i;
`endif
          if (cnt_reg == 16'd1) begin
`ifdef HERMES_NI_TX_CHECKSUM_EN
            state_next    = TRAILER;
`else
            state_next    = IDLE;
            pkt_sent_next = 1'b1;
`endif
          end
        end
      end

`ifdef HERMES_NI_TX_CHECKSUM_EN
      TRAILER: begin
        tx_o   = 1'b1;
        data_o = cs_reg;
        if (credit_i) begin
          state_next    = IDLE;
          pkt_sent_next = 1'b1;
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs stay quiet for the whole time reset is held
    if (!rst_ni) begin
      req_ready_o = 1'b0;
      pld_ready_o = 1'b0;
      tx_o        = 1'b0;
      data_o      = '0;
      busy_o      = 1'b0;
    end
  end

endmodule

// File: tb/tb_hermes_ni_tx.sv
// Randomised bench for hermes_ni_tx: packets are modelled as expected flit lists and compared
// transfer by transfer, with per-cycle checks of the handshake outputs.
module tb_hermes_ni_tx;

  localparam int FS = 32;
`ifdef HERMES_NI_TX_CHECKSUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [15:0]   req_target_i;
  logic [15:0]   req_len_i;
  logic          pld_valid_i;
  logic          pld_ready_o;
  logic [FS-1:0] pld_data_i;
  logic          tx_o;
  logic          credit_i;
  logic [FS-1:0] data_o;
  logic          busy_o;
  logic          pkt_sent_o;

  hermes_ni_tx #(.FLIT_SIZE(FS), .MAX_LEN(16'hFFFF)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_target_i (req_target_i),
    .req_len_i    (req_len_i),
    .pld_valid_i  (pld_valid_i),
    .pld_ready_o  (pld_ready_o),
    .pld_data_i   (pld_data_i),
    .tx_o         (tx_o),
    .credit_i     (credit_i),
    .data_o       (data_o),
    .busy_o       (busy_o),
    .pkt_sent_o   (pkt_sent_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [FS-1:0] data;
    logic          hold;
    logic          last;
  } flit_t;

  flit_t       exp_q[$];
  logic [31:0] req_q[$];
  logic [31:0] pld_q[$];
  logic        credit_q[$];
  int          xfer_cyc_q[$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_sent = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   accepted = 0;
  int   done = 0;
  logic sent_pend = 1'b0;
  logic credit_rand = 1'b0;
  int   pld_mode = 0;
  logic tog = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_flit(input logic [FS-1:0] d, input logic hold, input logic last);
    flit_t f;
    f.data = d;
    f.hold = hold;
    f.last = last;
    exp_q.push_back(f);
  endtask

  // Expected packet: header, size (len + trailer), payload, optional XOR trailer
  task automatic enqueue(input logic [15:0] target, input logic [15:0] len, input bit fixed);
    logic [FS-1:0] cs;
    logic [FS-1:0] sz;
    logic [FS-1:0] p;
    sz = 32'(len) + 32'(TRL);
    req_q.push_back({target, len});
    push_flit({16'h0, target}, 1'b1, 1'b0);
    push_flit(sz, 1'b1, (len == 16'd0) && (TRL == 0));
    cs = {16'h0, target} ^ sz;
    for (int i = 0; i < int'(len); i++) begin
      p = fixed ? 32'(32'hA + i) : $urandom;
      pld_q.push_back(p);
      cs = cs ^ p;
      push_flit(p, 1'b0, (i == int'(len) - 1) && (TRL == 0));
    end
    if (TRL == 1) push_flit(cs, 1'b1, 1'b1);
  endtask

  task automatic monitor();
    logic  exp_busy;
    logic  front_pld;
    logic  exp_tx;
    flit_t f;
    if (!rst_ni) begin
      chk("rst_ctl", 32'({req_ready_o, pld_ready_o, tx_o, busy_o, pkt_sent_o}), 32'h0);
      chk("rst_data", data_o, 32'h0);
      exp_q.delete();
      accepted  = 0;
      done      = 0;
      sent_pend = 1'b0;
      return;
    end
    exp_busy  = accepted > done;
    front_pld = exp_busy && exp_q.size() != 0 && !exp_q[0].hold;
    exp_tx    = !exp_busy ? 1'b0 : (front_pld ? pld_valid_i : 1'b1);
    chk("tx", 32'(tx_o), 32'(exp_tx));
    chk("busy", 32'(busy_o), 32'(exp_busy));
    chk("req_ready", 32'(req_ready_o), 32'(!exp_busy));
    chk("pld_ready", 32'(pld_ready_o), 32'(front_pld & credit_i));
    chk("pkt_sent", 32'(pkt_sent_o), 32'(sent_pend));
    if (!tx_o) chk("idle_data", data_o, 32'h0);
    sent_pend = 1'b0;
    if (tx_o && credit_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tx", 32'(tx_o), 32'h0);
      end else begin
        f = exp_q.pop_front();
        chk("flit", data_o, f.data);
        xfer_cyc_q.push_back(cyc);
        if (f.last) begin
          done++;
          n_sent++;
          sent_pend = 1'b1;
          $display("pkt %0d: last flit 0x%0h at cycle %0d", n_sent, data_o, cyc);
        end
      end
    end
  endtask

  task automatic tick();
    logic acc;
    logic pv;
    req_valid_i = rst_ni && req_q.size() != 0;
    {req_target_i, req_len_i} = (req_q.size() != 0) ? req_q[0] : 32'h0;
    if (credit_q.size() != 0) credit_i = credit_q.pop_front();
    else if (credit_rand) credit_i = ($urandom_range(0, 3) != 0);
    else credit_i = 1'b1;
    tog = !tog;
    case (pld_mode)
      0: pv = 1'b1;
      1: pv = tog;
      default: pv = $urandom_range(0, 1) != 0;
    endcase
    pld_valid_i = (pld_q.size() != 0) && pv;
    pld_data_i  = (pld_q.size() != 0) ? pld_q[0] : 32'h0;
    #1;
    acc = req_valid_i && req_ready_o;
    if (acc) begin
      void'(req_q.pop_front());
      acc_cyc = cyc;
    end
    if (pld_valid_i && pld_ready_o) void'(pld_q.pop_front());
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    cyc++;
    if (acc) accepted++;
    #1;
  endtask

  task automatic run_idle(input int bound);
    int n = 0;
    while ((req_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'h0);
    tick();
    tick();
  endtask

  initial begin
    int sent0;
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_target_i = '0; req_len_i = '0;
    pld_valid_i = 1'b0; pld_data_i = '0; credit_i = 1'b0;
    @(posedge clk_i);
    #1;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Basic packet, full credit: consecutive flits, one pulse
    xfer_cyc_q.delete();
    sent0 = n_sent;
    enqueue(16'h0102, 16'd3, 1'b1);
    run_idle(100);
    chk("t1_nflits", 32'(xfer_cyc_q.size()), 32'(5 + TRL));
    for (int k = 0; k < 5 + TRL; k++) chk("t1_cycle", 32'(xfer_cyc_q[k]), 32'(acc_cyc + 1 + k));
    chk("t1_sent", 32'(n_sent - sent0), 32'h1);

    // Credit withheld four cycles on the size flit
    xfer_cyc_q.delete();
    credit_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    enqueue(16'h0102, 16'd3, 1'b1);
    run_idle(100);
    chk("t2_nflits", 32'(xfer_cyc_q.size()), 32'(5 + TRL));
    chk("t2_hdr_cycle", 32'(xfer_cyc_q[0]), 32'(acc_cyc + 1));
    chk("t2_size_cycle", 32'(xfer_cyc_q[1]), 32'(acc_cyc + 6));
    chk("t2_pld_cycle", 32'(xfer_cyc_q[2]), 32'(acc_cyc + 7));

    // Zero-length packet
    xfer_cyc_q.delete();
    enqueue(16'h0102, 16'd0, 1'b1);
    run_idle(100);
    chk("t3_nflits", 32'(xfer_cyc_q.size()), 32'(2 + TRL));

    // Source toggling valid every cycle
    xfer_cyc_q.delete();
    pld_mode = 1;
    enqueue(16'h0304, 16'd4, 1'b0);
    run_idle(100);
    chk("t4_nflits", 32'(xfer_cyc_q.size()), 32'(6 + TRL));
    pld_mode = 0;

    // Back-to-back requests: one idle cycle between packets
    xfer_cyc_q.delete();
    enqueue(16'h0506, 16'd2, 1'b0);
    enqueue(16'h0708, 16'd2, 1'b0);
    run_idle(100);
    chk("t5_gap", 32'(xfer_cyc_q[4 + TRL] - xfer_cyc_q[3 + TRL]), 32'h2);

    // Reset in the middle of the payload abandons the packet
    sent0 = n_sent;
    enqueue(16'h0102, 16'd6, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    rst_ni = 1'b0;
    req_q.delete();
    pld_q.delete();
    tick();
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("t6_no_sent", 32'(n_sent - sent0), 32'h0);

    // Random traffic with random credit and source stalls
    credit_rand = 1'b1;
    pld_mode = 2;
    sent0 = n_sent;
    for (int k = 0; k < 40; k++) enqueue(16'($urandom), 16'($urandom_range(0, 10)), 1'b0);
    run_idle(5000);
    chk("rand_sent", 32'(n_sent - sent0), 32'd40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
